// File: rtl/indexed_add_pipe.sv
// Two-stage valid/ready adder with optional accumulator operand.
// Outputs (sum, carry, bit_o = sum[sel], sel_oob) from a registered S2.
module indexed_add_pipe #(
  parameter int WIDTH = 4,
  parameter int SELW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SELW-1:0]  sel,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             bit_o,
  output logic             sel_oob
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [SELW-1:0]  s1_sel_q, s1_sel_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             bit_q, bit_d;
  logic             oob_q, oob_d;

  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s1_advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] shifted;
  logic [31:0]      sel_wide;
  logic             oob_w;

  assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready;

  always_comb begin
    b_eff = b;
    unique case (1'b1)
      !acc_en:            b_eff = b;
      acc_en && acc_clr:  b_eff = '0;
      acc_en && !acc_clr: b_eff = acc_q;
      default:            b_eff = b;
    endcase
  end

  // Accumulator follows the accept so back-to-back
  // accumulate transactions chain without a bubble.
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      if (acc_en)       acc_d = b_eff + a;
      else if (acc_clr) acc_d = '0;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sel_d   = s1_sel_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b_eff;
      s1_sel_d   = sel;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  assign sum_w    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
  assign shifted  = sum_w[WIDTH-1:0] >> s1_sel_q;
  assign sel_wide = 32'(s1_sel_q);
  assign oob_w    = sel_wide >= 32'(WIDTH);

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    bit_d       = bit_q;
    oob_d       = oob_q;
    if (s1_advance) begin
      out_valid_d = 1'b1;
      sum_d       = sum_w[WIDTH-1:0];
      carry_d     = sum_w[WIDTH];
      bit_d       = oob_w ? 1'b0 : shifted[0];
      oob_d       = oob_w;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_q    <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      bit_q       <= 1'b0;
      oob_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_q    <= s1_sel_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      bit_q       <= bit_d;
      oob_q       <= oob_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign bit_o     = bit_q;
  assign sel_oob   = oob_q;

endmodule

// File: tb/tb_indexed_add_pipe.sv
// Directed bench for indexed_add_pipe (WIDTH=4 and WIDTH=6).
// Inputs change on negedge; outputs checked on negedge.
module tb_indexed_add_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv4 = 0, ir4, ae4 = 0, ac4 = 0;
  logic       ov4, or4 = 1, c4, bt4, ob4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  logic [1:0] sel4 = 0;

  logic       iv6 = 0, ir6, ae6 = 0, ac6 = 0;
  logic       ov6, or6 = 1, c6, bt6, ob6;
  logic [5:0] a6 = 0, b6 = 0, s6;
  logic [2:0] sel6 = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  indexed_add_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .sel(sel4),
    .acc_en(ae4), .acc_clr(ac4),
    .out_valid(ov4), .out_ready(or4),
    .sum(s4), .carry(c4), .bit_o(bt4), .sel_oob(ob4)
  );

  indexed_add_pipe #(.WIDTH(6)) u6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv6), .in_ready(ir6),
    .a(a6), .b(b6), .sel(sel6),
    .acc_en(ae6), .acc_clr(ac6),
    .out_valid(ov6), .out_ready(or6),
    .sum(s6), .carry(c6), .bit_o(bt6), .sel_oob(ob6)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp4(input string tag, input logic [3:0] s,
                      input logic c, input logic bt);
    chk({tag, ".valid"}, 64'(ov4), 64'd1);
    chk({tag, ".sum"},   64'(s4),  64'(s));
    chk({tag, ".carry"}, 64'(c4),  64'(c));
    chk({tag, ".bit"},   64'(bt4), 64'(bt));
    chk({tag, ".oob"},   64'(ob4), 64'd0);
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] s, input logic en,
                        input logic clr);
    iv4 = 1'b1; a4 = a; b4 = b; sel4 = s; ae4 = en; ac4 = clr;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst.out_valid", 64'(ov4), 64'd0);
    chk("rst.in_ready",  64'(ir4), 64'd1);
    chk("rst.sum",       64'(s4),  64'd0);
    chk("rst.carry",     64'(c4),  64'd0);
    chk("rst.bit",       64'(bt4), 64'd0);
    chk("rst.oob",       64'(ob6), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2 + 12 = 14, bit 3 set
    drive4(4'b0010, 4'b1100, 2'd3, 0, 0);
    chk("t1.in_ready", 64'(ir4), 64'd1);
    @(negedge clk);
    iv4 = 1'b0;
    chk("t1.lat1", 64'(ov4), 64'd0);
    @(negedge clk);
    exp4("t1", 4'd14, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1.drain", 64'(ov4), 64'd0);

    // F + 1 wraps to 0 with carry
    drive4(4'hF, 4'h1, 2'd0, 0, 0);
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    exp4("t2", 4'd0, 1'b1, 1'b0);
    @(negedge clk);

    // back-to-back accumulate: 5, 12, 2
    drive4(4'd5, 4'hA, 2'd0, 1, 1);
    @(negedge clk);
    drive4(4'd7, 4'hA, 2'd2, 1, 0);
    @(negedge clk);
    exp4("acc1", 4'd5, 1'b0, 1'b1);
    drive4(4'd6, 4'hA, 2'd1, 1, 0);
    @(negedge clk);
    iv4 = 1'b0;
    exp4("acc2", 4'd12, 1'b0, 1'b1);
    @(negedge clk);
    exp4("acc3", 4'd2, 1'b1, 1'b1);
    drive4(4'd0, 4'hA, 2'd0, 1, 0);
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    exp4("acc_end", 4'd2, 1'b0, 1'b0);
    @(negedge clk);

    // backpressure: 4 offered, 2 accepted while stalled
    or4 = 1'b0;
    drive4(4'd1, 4'd1, 2'd1, 0, 0);
    chk("bp.rdyA", 64'(ir4), 64'd1);
    @(negedge clk);
    drive4(4'd2, 4'd2, 2'd1, 0, 0);
    chk("bp.rdyB", 64'(ir4), 64'd1);
    @(negedge clk);
    drive4(4'd3, 4'd3, 2'd1, 0, 0);
    chk("bp.rdyC0", 64'(ir4), 64'd0);
    exp4("bp.A0", 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp.rdyC1", 64'(ir4), 64'd0);
    exp4("bp.A1", 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp.rdyC2", 64'(ir4), 64'd0);
    exp4("bp.A2", 4'd2, 1'b0, 1'b1);
    or4 = 1'b1;
    #1;
    chk("bp.rdy_comb", 64'(ir4), 64'd1);
    @(negedge clk);
    exp4("bp.B", 4'd4, 1'b0, 1'b0);
    drive4(4'd4, 4'd4, 2'd1, 0, 0);
    chk("bp.rdyD", 64'(ir4), 64'd1);
    @(negedge clk);
    iv4 = 1'b0;
    exp4("bp.C", 4'd6, 1'b0, 1'b1);
    @(negedge clk);
    exp4("bp.D", 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp.empty", 64'(ov4), 64'd0);

    // WIDTH=6: out-of-range and in-range index
    iv6 = 1'b1; a6 = 6'h3F; b6 = 6'h00; sel6 = 3'd7;
    @(negedge clk);
    a6 = 6'h20; sel6 = 3'd5;
    @(negedge clk);
    iv6 = 1'b0;
    chk("w6a.valid", 64'(ov6), 64'd1);
    chk("w6a.sum",   64'(s6),  64'h3F);
    chk("w6a.carry", 64'(c6),  64'd0);
    chk("w6a.bit",   64'(bt6), 64'd0);
    chk("w6a.oob",   64'(ob6), 64'd1);
    @(negedge clk);
    chk("w6b.sum",   64'(s6),  64'h20);
    chk("w6b.bit",   64'(bt6), 64'd1);
    chk("w6b.oob",   64'(ob6), 64'd0);
    @(negedge clk);

    // reset with both stages full
    or4 = 1'b0;
    drive4(4'd3, 4'd0, 2'd0, 1, 1);
    @(negedge clk);
    drive4(4'd4, 4'd0, 2'd0, 1, 0);
    @(negedge clk);
    iv4 = 1'b0;
    chk("mr.full_valid", 64'(ov4), 64'd1);
    chk("mr.full_rdy",   64'(ir4), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr.valid", 64'(ov4), 64'd0);
    chk("mr.rdy",   64'(ir4), 64'd1);
    chk("mr.sum",   64'(s4),  64'd0);
    chk("mr.carry", 64'(c4),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    or4 = 1'b1;
    drive4(4'd9, 4'd0, 2'd0, 1, 0);
    @(negedge clk);
    iv4 = 1'b0;
    chk("mr.no_stale", 64'(ov4), 64'd0);
    @(negedge clk);
    exp4("mr.next", 4'd9, 1'b0, 1'b1);
    @(negedge clk);
    chk("mr.drain", 64'(ov4), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
